// File: rtl/fir_in_feeder.sv
// Input pacing stage for the serial FIR: buffers upstream samples in a small
// FIFO and releases one every PERIOD clocks, inserting zeros on underrun.
module fir_in_feeder #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int PERIOD = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     clr_flags,
    output logic [WIDTH-1:0]         xOut,
    output logic                     sample,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(PERIOD);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    pc;
    logic             full, empty, push, tick, pop;

    assign full      = (level == (AW+1)'(DEPTH));
    assign empty     = (level == '0);
    assign din_ready = !full;
    assign push      = din_valid && din_ready;
    assign tick      = run && (pc == PW'(PERIOD - 1));
    // Pop decision uses pre-edge occupancy, so a same-edge push into an
    // empty FIFO is not visible to this tick.
    assign pop       = tick && !empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            pc       <= '0;
            xOut     <= '0;
            sample   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (run)
                pc <= tick ? '0 : pc + 1'b1;

            sample <= tick;
            if (tick)
                xOut <= empty ? '0 : mem[rd_ptr];

            // Set has priority over clear on the same edge.
            if (tick && empty)
                underrun <= 1'b1;
            else if (clr_flags)
                underrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fir_in_feeder.sv
// Scoreboard bench for fir_in_feeder: expected strobes are queued by the
// stimulus and checked by an independent monitor on every sample strobe.
module tb_fir_in_feeder;
    localparam int WIDTH = 16, DEPTH = 8, PERIOD = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             run = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic             clr_flags = 1'b0;
    logic [WIDTH-1:0] xOut;
    logic             sample;
    logic             underrun;
    logic [3:0]       level;

    fir_in_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PERIOD(PERIOD)) dut (
        .clk(clk), .reset(reset), .run(run), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .clr_flags(clr_flags), .xOut(xOut),
        .sample(sample), .underrun(underrun), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_cmp = 0;
    int   n_err = 0;

    // Cycle k is the period following rising edge k after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_strobe(input int c, input logic [WIDTH-1:0] d);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset && sample) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: xOut=%0h at cycle %0d, none expected", xOut, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("strobe_xout", {16'h0, xOut}, {16'h0, e.data});
            end
        end
    end

    task automatic wait_cyc(input int c);
        int guard;
        guard = 0;
        while (cyc < c && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != c) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_cyc: reached %0d wanted %0d", cyc, c);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run = 1'b0;
        din_valid = 1'b0;
        clr_flags = 1'b0;
        #1;
        chk("rst_level", level, 0);
        chk("rst_xout", xOut, 0);
        chk("rst_sample", sample, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_din_ready", din_ready, 1);
        chk("pending_strobes", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // 1: steady stream
        do_reset();
        run = 1'b1;
        expect_strobe(32, 16'h0001);
        expect_strobe(64, 16'h0002);
        expect_strobe(96, 16'h0003);
        expect_strobe(128, 16'h0004);
        din = 16'h0001; din_valid = 1'b1;
        for (int i = 1; i < 4; i++) begin
            wait_cyc(i);
            din = 16'(i + 1);
        end
        wait_cyc(4);
        din_valid = 1'b0;
        chk("t1_level_peak", level, 4);
        wait_cyc(32);
        chk("t1_level_after_pop", level, 3);
        wait_cyc(130);
        chk("t1_underrun", underrun, 0);
        chk("t1_level_drained", level, 0);

        // 2: underrun and flag clear
        do_reset();
        run = 1'b1;
        expect_strobe(32, 16'h0000);
        wait_cyc(33);
        chk("t2_underrun_set", underrun, 1);
        clr_flags = 1'b1;
        wait_cyc(34);
        clr_flags = 1'b0;
        chk("t2_underrun_clr", underrun, 0);
        run = 1'b0;

        // 3: full FIFO, extra sample refused
        do_reset();
        din = 16'h8000; din_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            wait_cyc(i);
            din = 16'h8000 + 16'(i);
        end
        chk("t3_level_full", level, 8);
        chk("t3_ready_full", din_ready, 0);
        wait_cyc(9);
        chk("t3_level_refused", level, 8);
        run = 1'b1;
        din_valid = 1'b0;
        for (int k = 0; k < 8; k++)
            expect_strobe(41 + 32 * k, 16'h8000 + 16'(k));
        expect_strobe(41 + 32 * 8, 16'h0000);
        wait_cyc(40);
        chk("t3_ready_before_pop", din_ready, 0);
        wait_cyc(41);
        chk("t3_ready_after_pop", din_ready, 1);
        chk("t3_level_after_pop", level, 7);
        wait_cyc(41 + 32 * 8 + 1);
        chk("t3_underrun_end", underrun, 1);

        // 4: push on an empty tick edge; clear on an empty tick edge
        do_reset();
        run = 1'b1;
        expect_strobe(32, 16'h0000);
        expect_strobe(64, 16'h1234);
        expect_strobe(96, 16'h0000);
        wait_cyc(31);
        din = 16'h1234; din_valid = 1'b1;
        wait_cyc(32);
        din_valid = 1'b0;
        chk("t4a_level", level, 1);
        chk("t4a_underrun", underrun, 1);
        wait_cyc(64);
        chk("t4a_level_popped", level, 0);
        wait_cyc(95);
        clr_flags = 1'b1;
        wait_cyc(96);
        chk("t4b_set_wins", underrun, 1);
        wait_cyc(97);
        clr_flags = 1'b0;
        chk("t4b_clr_after", underrun, 0);

        // 5: run gating, then reset with data buffered
        do_reset();
        run = 1'b1;
        expect_strobe(52, 16'h00AA);
        wait_cyc(10);
        run = 1'b0;
        wait_cyc(30);
        run = 1'b1;
        wait_cyc(39);
        din = 16'h00AA; din_valid = 1'b1;
        wait_cyc(40);
        din_valid = 1'b0;
        chk("t5_level_one", level, 1);
        wait_cyc(52);
        chk("t5_level_popped", level, 0);
        chk("t5_underrun", underrun, 0);
        din = 16'h0011; din_valid = 1'b1;
        wait_cyc(53); din = 16'h0022;
        wait_cyc(54); din = 16'h0033;
        wait_cyc(55);
        din_valid = 1'b0;
        chk("t5_level_three", level, 3);
        do_reset();
        run = 1'b1;
        expect_strobe(32, 16'h0000);
        wait_cyc(33);
        chk("t5_level_post_rst", level, 0);
        chk("t5_underrun_post_rst", underrun, 1);
        run = 1'b0;

        chk("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
